// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared core types and constants for fetch and control decode
package rv_core_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter with +4 increment and word-aligned redirect
module fetch_pc
  import rv_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc_en,
  input  logic            i_redirect_en,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_target_aligned;

  assign w_target_aligned = i_target & ~XLEN'(3);

  // Redirect wins over sequential advance; the increment wraps naturally at 2^XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_en) begin
      r_pc <= w_target_aligned;
    end else if (i_inc_en) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with one outstanding memory request
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic            r_kill;
  logic            w_kill_nxt;
  logic            w_capture;
  logic            w_req_fire;
  logic [XLEN-1:0] w_pc;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;

  fetch_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .i_inc_en      (w_capture),
    .i_redirect_en (redirect_valid),
    .i_target      (redirect_target),
    .o_pc          (w_pc)
  );

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = w_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // Next-state logic; kill marks an in-flight request whose data belongs to a squashed path.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_req_fire) begin
          w_state_nxt = S_WAIT;
          w_kill_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_kill_nxt = 1'b0;
          if (r_kill || redirect_valid) begin
            w_state_nxt = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || instr_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  // State and kill registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  // Capture the returned word together with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= ILEN'(NOP_INSTR);
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= imem_rsp_data;
      r_instr_pc <= w_pc;
    end
  end

  assign instr_valid = (r_state == S_HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign opcode      = r_instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;

  bit          mem_pend = 0;
  int          mem_due  = 0;
  logic [31:0] mem_addr = 32'h0;

  ent_t req_log[$];
  ent_t del_log[$];

  // program-order model state
  logic [31:0] exp_pc = 32'h0;
  bit          live = 0, exp_chk = 0, exp_val = 0;
  bit          p_hold = 0, p_stall = 0, p_redir = 0, p_valid = 0;
  logic [31:0] p_instr, p_pc, p_addr, p_tgt;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .opcode          (opcode),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = 7'h33;
      2'd1:    op = 7'h03;
      2'd2:    op = 7'h23;
      default: op = 7'h63;
    endcase
    if (a == 32'h0) return 32'h0020_8033;
    return {a[26:2], op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // memory responder: one response lat cycles after each accepted request
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mem_pend && cyc == mem_due) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
      mem_pend       = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  end

  // compare process: transaction-level model of program order checked every cycle
  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      live = 0; exp_chk = 0; p_hold = 0; p_stall = 0; p_redir = 0; p_valid = 0;
      exp_pc = 32'h0;
    end else begin
      if (exp_chk) chk("rsp_to_valid", instr_valid, exp_val);
      if (p_hold) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, p_instr);
        chk("hold_pc", instr_pc, p_pc);
      end
      if (p_stall) begin
        chk("stall_valid", imem_req_valid, 1);
        chk("stall_addr", imem_req_addr, p_addr);
      end
      if (p_redir) begin
        chk("redir_drop", instr_valid, 0);
        if (imem_req_valid) chk("redir_addr", imem_req_addr, p_tgt);
      end
      if (instr_valid) begin
        w = mem_word(instr_pc);
        chk("opcode", opcode, w[6:0]);
        chk("one_at_a_time", imem_req_valid, 0);
        if (!p_valid) begin
          chk("del_pc", instr_pc, exp_pc);
          chk("del_instr", instr, w);
          del_log.push_back('{instr_pc, cyc});
        end
      end
      exp_chk = imem_rsp_valid;
      exp_val = imem_rsp_valid && live && !redirect_valid;
      if (imem_rsp_valid) live = 0;
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        req_log.push_back('{imem_req_addr, cyc});
        mem_pend = 1;
        mem_addr = imem_req_addr;
        mem_due  = cyc + lat;
        live     = !redirect_valid;
      end
      if (redirect_valid) begin
        exp_pc = redirect_target & ~32'h3;
        live   = 0;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'h4;
      end
      p_hold  = instr_valid && !instr_ready && !redirect_valid;
      p_instr = instr;
      p_pc    = instr_pc;
      p_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      p_addr  = imem_req_addr;
      p_redir = redirect_valid;
      p_tgt   = redirect_target & ~32'h3;
      p_valid = instr_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    mem_pend = 0;
    req_log.delete();
    del_log.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, instr_valid, 1);
  endtask

  task automatic wait_req(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(imem_req_valid && imem_req_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, imem_req_valid && imem_req_ready, 1);
  endtask

  initial begin
    int cnt;

    // reset values and basic streaming with a 1-cycle memory
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    step(2);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_opcode", opcode, 7'h13);
    do_reset();
    step(12);
    chk("t1_nreq", req_log.size() >= 3, 1);
    chk("t1_ndel", del_log.size() >= 1, 1);
    if (req_log.size() >= 3) begin
      chk("t1_req0", req_log[0].addr, 32'h0);
      chk("t1_req1", req_log[1].addr, 32'h4);
      chk("t1_req2", req_log[2].addr, 32'h8);
      chk("t1_issue_gap", req_log[1].cyc - req_log[0].cyc, 3);
    end
    if (del_log.size() >= 1 && req_log.size() >= 1) begin
      chk("t1_del_pc", del_log[0].addr, 32'h0);
      chk("t1_latency", del_log[0].cyc - req_log[0].cyc, 2);
    end

    // downstream back-pressure: held instruction, no new request until consumed
    instr_ready = 1'b0;
    do_reset();
    wait_valid("t2_wait_valid", 20);
    chk("t2_opcode", opcode, 7'h33);
    chk("t2_instr", instr, 32'h0020_8033);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", instr_valid, 1);
      chk("t2_hold_pc", instr_pc, 32'h0);
      chk("t2_no_req", imem_req_valid, 0);
    end
    @(posedge clk); #1;
    chk("t2_one_req", req_log.size(), 1);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    @(negedge clk);
    chk("t2_next_req_valid", imem_req_valid, 1);
    chk("t2_next_req_addr", imem_req_addr, 32'h4);

    // memory stall on the request to 0x4
    do_reset();
    wait_valid("t3_wait_valid", 20);
    @(posedge clk); #1;
    imem_req_ready = 1'b0; instr_ready = 1'b1;
    step(1);
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_valid", imem_req_valid, 1);
      chk("t3_stall_addr", imem_req_addr, 32'h4);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    step(1);
    imem_req_ready = 1'b0;
    step(6);
    cnt = 0;
    foreach (req_log[i]) if (req_log[i].addr == 32'h4) cnt++;
    chk("t3_one_accept", cnt, 1);
    chk("t3_nreq", req_log.size(), 2);

    // redirect while waiting on a slow response
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 4;
    do_reset();
    wait_req("t4_wait_req", 20);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_target = 32'h100; lat = 1;
    step(1);
    redirect_valid = 1'b0;
    step(15);
    cnt = 0;
    foreach (del_log[i]) if (del_log[i].addr == 32'h0) cnt++;
    chk("t4_dropped", cnt, 0);
    chk("t4_nreq", req_log.size() >= 2, 1);
    chk("t4_ndel", del_log.size() >= 1, 1);
    if (req_log.size() >= 2) chk("t4_req_addr", req_log[1].addr, 32'h100);
    if (del_log.size() >= 1) chk("t4_del_pc", del_log[0].addr, 32'h100);

    // redirect coincident with the response, unaligned target
    do_reset();
    wait_req("t5_wait_req", 20);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step(1);
    redirect_valid = 1'b0;
    step(10);
    cnt = 0;
    foreach (del_log[i]) if (del_log[i].addr == 32'h0) cnt++;
    chk("t5_dropped", cnt, 0);
    chk("t5_nreq", req_log.size() >= 2, 1);
    chk("t5_ndel", del_log.size() >= 1, 1);
    if (req_log.size() >= 2) chk("t5_req_addr", req_log[1].addr, 32'h200);
    if (del_log.size() >= 1) chk("t5_del_pc", del_log[0].addr, 32'h200);

    // reset during hold, then a stale response after a reset mid-request
    instr_ready = 1'b0;
    do_reset();
    wait_valid("t6_wait_valid", 20);
    @(posedge clk); #1;
    rst = 1'b1;
    step(2);
    @(negedge clk);
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_req", imem_req_valid, 0);
    @(posedge clk); #1;
    req_log.delete(); del_log.delete();
    rst = 1'b0; instr_ready = 1'b1; lat = 5;
    wait_req("t6_wait_req", 20);
    chk("t6_first_addr", imem_req_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; imem_req_ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(8);
    chk("t6_stale_ignored", del_log.size(), 0);
    chk("t6_stale_gone", mem_pend, 0);
    req_log.delete(); del_log.delete();
    imem_req_ready = 1'b1; lat = 1;
    step(8);
    chk("t6_ndel", del_log.size() >= 1, 1);
    if (del_log.size() >= 1) chk("t6_del_pc", del_log[0].addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
